// File: rtl/beep_seq_if.sv
// CPU-side bus of the note sequencer: write strobe, write data and the status word.
interface beep_seq_if;
  logic        we;
  logic [15:0] wdata;
  logic [31:0] status;

  modport master (output we, output wdata, input status);
  modport slave  (input we, input wdata, output status);
endinterface

// File: rtl/beep_seq.sv
// Note sequencer for the beep tone generator: queues (note, duration) words
// in a small FIFO and plays them with a fixed silent gap between notes.
module beep_seq #(
  parameter int DEPTH = 8,
  parameter int TICK  = 625000,
  parameter int GAP   = 62500
) (
  input  logic           clk,
  input  logic           reset,
  beep_seq_if.slave      bus,
  output logic [7:0]     mode,
  output logic           playing
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PRE_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [3:0]       DEPTH_C  = 4'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t           state, state_d;
  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [3:0]       count;
  logic             ovf;
  logic [PRE_W-1:0] presc, presc_d;
  logic [7:0]       remaining, remaining_d;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
  logic [7:0]       mode_d;
  logic             pop, push, drop, flush, empty, full, has_dur;
  logic [15:0]      head;

  assign flush   = bus.we && (bus.wdata == 16'h0000);
  assign has_dur = (bus.wdata[15:8] != 8'd0);
  assign empty   = (count == 4'd0);
  assign full    = (count == DEPTH_C);
  assign head    = mem[rd_ptr];
  assign playing = (state != S_IDLE);
  assign bus.status = {24'h0, ovf, playing, full, empty, count};

  // A push is still taken when full if the sequencer frees a slot in the same cycle.
  assign push = bus.we && !flush && has_dur && (!full || pop);
  assign drop = bus.we && !flush && has_dur && full && !pop;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    mode_d      = mode;
    presc_d     = presc;
    remaining_d = remaining;
    gap_cnt_d   = gap_cnt;
    pop         = 1'b0;
    case (state)
      S_IDLE: begin
        mode_d = 8'd0;
        if (!empty) pop = 1'b1;
      end
      S_PLAY: begin
        if (presc == PRE_LAST) begin
          presc_d = '0;
          if (remaining == 8'd1) begin
            if (GAP > 0) begin
              mode_d    = 8'd0;
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end else if (!empty) begin
              pop = 1'b1;
            end else begin
              mode_d  = 8'd0;
              state_d = S_IDLE;
            end
          end else begin
            remaining_d = remaining - 8'd1;
          end
        end else begin
          presc_d = presc + PRE_W'(1);
        end
      end
      S_GAP: begin
        mode_d = 8'd0;
        if (gap_cnt == GAP_LAST) begin
          if (!empty) pop = 1'b1;
          else        state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      mode_d      = head[7:0];
      remaining_d = head[15:8];
      presc_d     = '0;
      state_d     = S_PLAY;
    end

    // Flush overrides anything the sequencer decided this cycle.
    if (flush) begin
      pop     = 1'b0;
      mode_d  = 8'd0;
      state_d = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mode      <= 8'd0;
      presc     <= '0;
      remaining <= 8'd0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_d;
      mode      <= mode_d;
      presc     <= presc_d;
      remaining <= remaining_d;
      gap_cnt   <= gap_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
      ovf    <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + 4'd1;
      else if (pop && !push) count <= count - 4'd1;
      if (drop) ovf <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wdata;
  end

endmodule

// File: tb/tb_beep_seq.sv
// Self-checking bench for beep_seq: directed steps plus random writes, compared
// every cycle against a queue-based model that counts whole-note cycle totals.
module tb_beep_seq;

  localparam int TICK  = 4;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mode;
  logic       playing;

  beep_seq_if bus ();

  beep_seq #(.DEPTH(DEPTH), .TICK(TICK), .GAP(GAP)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .mode    (mode),
    .playing (playing)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of words, a note lasts dur*TICK cycles, a gap lasts GAP cycles.
  logic [15:0] q [$];
  int unsigned play_left, gap_left;
  bit          busy, in_gap, m_ovf;
  logic [7:0]  m_mode;

  task automatic model_reset();
    q.delete();
    play_left = 0; gap_left = 0;
    busy = 0; in_gap = 0; m_ovf = 0; m_mode = 8'd0;
  endtask

  function automatic bit model_pops();
    if (!busy) return q.size() > 0;
    if (!in_gap && play_left == 1) return (GAP == 0) && (q.size() > 0);
    if (in_gap && gap_left == 1) return q.size() > 0;
    return 1'b0;
  endfunction

  task automatic model_load();
    logic [15:0] e;
    e = q.pop_front();
    m_mode    = e[7:0];
    play_left = int'(e[15:8]) * TICK;
    busy      = 1;
    in_gap    = 0;
  endtask

  task automatic model_step(input logic w, input logic [15:0] d);
    bit p;
    if (w && d == 16'h0000) begin
      q.delete();
      m_ovf = 0; busy = 0; in_gap = 0; m_mode = 8'd0;
      return;
    end
    p = model_pops();
    if (!busy) begin
      if (p) model_load();
    end else if (!in_gap) begin
      if (play_left == 1) begin
        if (GAP > 0) begin m_mode = 8'd0; in_gap = 1; gap_left = GAP; end
        else if (p)  model_load();
        else begin   busy = 0; m_mode = 8'd0; end
      end else play_left--;
    end else begin
      if (gap_left == 1) begin
        if (p) model_load();
        else begin busy = 0; in_gap = 0; end
      end else gap_left--;
    end
    if (w && d[15:8] != 8'd0) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1;
    end
  endtask

  function automatic logic [31:0] model_status();
    return {24'h0, m_ovf, busy, q.size() == DEPTH, q.size() == 0, 4'(q.size())};
  endfunction

  task automatic compare();
    check("mode",    32'(mode),    32'(m_mode));
    check("playing", 32'(playing), 32'(busy));
    check("status",  bus.status,   model_status());
  endtask

  // Drive one cycle's inputs, let the edge happen, then check 1 time unit later.
  task automatic cycle(input logic w, input logic [15:0] d);
    bus.we = w; bus.wdata = d;
    @(posedge clk);
    model_step(w, d);
    #1;
    compare();
  endtask

  task automatic run_until_idle(input string tag, input int limit);
    int k = 0;
    while ((playing || bus.status[3:0] != 4'd0) && k < limit) begin
      cycle(1'b0, 16'h0000);
      k++;
    end
    check(tag, {30'h0, playing, bus.status[4]}, 32'h1);
  endtask

  logic [7:0]  exp2 [17] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd2, 8'd2, 8'd2, 8'd2,
                             8'd0, 8'd0, 8'd3, 8'd3, 8'd3, 8'd3, 8'd0};
  logic [7:0]  got2 [17];
  int          n, k, r, peak;
  logic        w;
  logic [15:0] d;

  initial begin
    reset = 1'b1; bus.we = 1'b0; bus.wdata = 16'h0000;
    model_reset();
    #23 reset = 1'b0;
    compare();
    check("reset_status", bus.status, 32'h10);

    // Step 1: single note, 3 ticks of note 5.
    cycle(1'b1, 16'h0305);
    check("s1_count_after_write", 32'(bus.status[3:0]), 32'd1);
    check("s1_mode_after_write",  32'(mode), 32'd0);
    cycle(1'b0, 16'h0000);
    check("s1_mode_start", 32'(mode), 32'd5);
    n = 0; k = 0;
    while (mode == 8'd5 && k < 40) begin n++; cycle(1'b0, 16'h0000); k++; end
    check("s1_note_len", n, 32'(3 * TICK));
    check("s1_gap_play0", 32'(playing), 32'd1);
    cycle(1'b0, 16'h0000);
    check("s1_gap_play1", 32'(playing), 32'd1);
    cycle(1'b0, 16'h0000);
    check("s1_play_fall", 32'(playing), 32'd0);
    check("s1_empty", 32'(bus.status[4]), 32'd1);

    // Step 2: three back-to-back one-tick notes.
    cycle(1'b1, 16'h0101);
    peak = int'(bus.status[3:0]);
    for (int i = 0; i < 17; i++) begin
      if (i == 0)      cycle(1'b1, 16'h0102);
      else if (i == 1) cycle(1'b1, 16'h0103);
      else             cycle(1'b0, 16'h0000);
      got2[i] = mode;
      if (int'(bus.status[3:0]) > peak) peak = int'(bus.status[3:0]);
    end
    for (int i = 0; i < 17; i++) check($sformatf("s2_seq[%0d]", i), 32'(got2[i]), 32'(exp2[i]));
    check("s2_peak", peak, 32'd2);
    run_until_idle("s2_drain", 50);

    // Step 3: overflow while a long note plays.
    cycle(1'b1, 16'h0A01);
    cycle(1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'h0107);
    check("s3_count", 32'(bus.status[3:0]), 32'd4);
    check("s3_full",  32'(bus.status[5]),   32'd1);
    check("s3_ovf",   32'(bus.status[7]),   32'd1);

    // Step 4: zero-duration word is ignored, rest entry plays silently.
    run_until_idle("s4_drain", 500);
    check("s4_ovf_sticky", 32'(bus.status[7]), 32'd1);
    cycle(1'b1, 16'h0009);
    check("s4_zero_dur_status", bus.status, 32'h90);
    cycle(1'b1, 16'h0200);
    n = 0; k = 0;
    cycle(1'b0, 16'h0000);
    while (playing && k < 60) begin
      if (mode != 8'd0) k = k + 100;
      n++;
      cycle(1'b0, 16'h0000);
      k++;
    end
    check("s4_rest_len_with_gap", n, 32'(2 * TICK + GAP));

    // Step 5: flush mid-note.
    cycle(1'b1, 16'h0306);
    cycle(1'b0, 16'h0000);
    cycle(1'b0, 16'h0000);
    cycle(1'b1, 16'h0101);
    cycle(1'b0, 16'h0000);
    check("s5_mid_note", 32'(mode), 32'd6);
    cycle(1'b1, 16'h0000);
    check("s5_flush_status", bus.status, 32'h10);
    check("s5_flush_mode", 32'(mode), 32'd0);

    // Step 6: push into a full FIFO on the exact cycle of an internal pop.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 16'h0100 | 16'(i));
    k = 0;
    while (!(model_pops() && q.size() == DEPTH) && k < 50) begin cycle(1'b0, 16'h0000); k++; end
    check("s6_pop_wait", 32'(k < 50), 32'd1);
    cycle(1'b1, 16'h0207);
    check("s6_count", 32'(bus.status[3:0]), 32'd4);
    check("s6_ovf",   32'(bus.status[7]),   32'd0);
    check("s6_mode_loaded", 32'(mode), 32'd2);
    #1 reset = 1'b1;
    #1;
    check("s6_reset_mode",   32'(mode), 32'd0);
    check("s6_reset_status", bus.status, 32'h10);
    #1 reset = 1'b0;
    model_reset();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      w = 1'b1;
      if (r < 2)       d = 16'h0000;
      else if (r < 7)  d = {8'h00, 8'($urandom_range(1, 15))};
      else if (r < 30) d = {8'($urandom_range(1, 3)), 8'($urandom_range(0, 15))};
      else begin       w = 1'b0; d = 16'(($urandom_range(0, 65535))); end
      cycle(w, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
